ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-port arbiter sharing the single-port synchronous data RAM between requester A (CPU data
//  port) and requester B (loader/DMA). Each cycle grants at most one requester; drives the RAM's
//  data/load/address and routes the RAM's registered read word back to the owning requester.
//  B may lock the RAM for bursts; a counter caps lock length so A cannot starve. Sits between
//  the CPU/loader and the RAM instance in the top level.
// PARAMETERS
//  AW        13  address width (8192 words)
//  DW        16  data word width
//  MAX_LOCK  16  max consecutive cycles B may hold the RAM under lock (>=1)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  a_req        in   1   A requests an access this cycle
//  a_we         in   1   A access is a write
//  a_addr       in   AW  A word address
//  a_wdata      in   DW  A write data
//  a_gnt        out  1   A access accepted this cycle (combinational)
//  a_rvalid     out  1   A read data valid (cycle after A read grant)
//  a_rdata      out  DW  A read data
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid/b_rdata  as A, for requester B
//  b_lock       in   1   B requests to keep ownership on following cycles
//  ram_data     out  DW  to RAM data
//  ram_load     out  1   to RAM load
//  ram_address  out  AW  to RAM address
//  ram_out      in   DW  from RAM out (valid 1 cycle after address sampled)
// BEHAVIOUR
//  - Access accepted when x_req && x_gnt at posedge; RAM samples same edge.
//  - Grant (combinational from req + state): a_gnt & b_gnt never both 1.
//    * lock_active && b_req: B granted, A waits.
//    * Only one requesting: that one granted.
//    * Both requesting, no lock: round-robin; prio register names favoured port; after a
//      grant, prio moves to the other port. Reset value prio=A.
//  - RAM drive: granted port's addr/wdata; ram_load = granted && we. No grant: ram_load=0,
//    ram_address=0, ram_data=0.
//  - Reads: registered tag {valid, owner} set on read grant; next cycle x_rvalid=1 for that
//    owner, x_rdata = ram_out. Non-owner rdata = 0. Writes produce no rvalid.
//  - Latency: grant same cycle, read data 1 cycle after grant; back-to-back reads every cycle.
//  - Lock FSM: UNLOCKED -> LOCKED when B granted with b_lock=1; lock_cnt counts B grants in
//    LOCKED. LOCKED -> UNLOCKED when b_lock=0, b_req=0, or lock_cnt reaches MAX_LOCK; on the
//    cap exit prio=A, and A (if requesting) is granted next cycle before B may re-lock.
//  - Lock entry on a grant counts as cycle 1; lock_cnt width = clog2(MAX_LOCK)+1.
//  - Reset (incl. mid-operation): prio=A, state UNLOCKED, lock_cnt=0, all rvalid=0, rdata=0;
//    read pending at reset edge is dropped (no rvalid). Grants/RAM drive stay combinational,
//    but are forced to 0 while reset=1.
//  - Address/data pass through unchanged; no wrap or arithmetic on addresses.
// TESTING
//  1 reset; A read addr 5 (RAM[5]=16'h0003) -> a_gnt same cycle, a_rvalid=1,a_rdata=16'h0003 next.
//  2 A,B both req reads every cycle for 4 cycles -> grants A,B,A,B; rvalid owner follows 1 cycle.
//  3 B write addr 100 data 16'hBEEF, then A read 100 -> a_rdata=16'hBEEF; no b_rvalid on write.
//  4 MAX_LOCK=4, B req+lock with A req held -> B granted 4 cycles, A on 5th, then B resumes.
//  5 A read granted, reset asserted next edge -> a_rvalid stays 0; all outputs 0 during reset.
//  6 No requests -> ram_load=0, ram_address=0, both gnt=0, prio unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port synchronous data RAM: A (CPU) and B (loader/DMA) with
// round-robin priority, a length-capped B burst lock, and read-data routing to the owning port.
module ram_arbiter #(
   parameter int AW       = 13,
   parameter int DW       = 16,
   parameter int MAX_LOCK = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   input  logic          b_lock,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic [DW-1:0] ram_data,
   output logic          ram_load,
   output logic [AW-1:0] ram_address,
   input  logic [DW-1:0] ram_out
);
   localparam int CW = $clog2(MAX_LOCK) + 1;

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   state_t        state, state_nx;
   logic          prio_b, prio_b_nx;
   logic [CW-1:0] lock_cnt, lock_cnt_nx;
   logic          rd_vld, rd_own;

   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (!reset) begin
         if (state == LOCKED && b_req) begin
            b_gnt = 1'b1;
         end else if (a_req && b_req) begin
            b_gnt = prio_b;
            a_gnt = !prio_b;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   always_comb begin
      ram_load    = 1'b0;
      ram_address = '0;
      ram_data    = '0;
      if (a_gnt) begin
         ram_load    = a_we;
         ram_address = a_addr;
         ram_data    = a_wdata;
      end else if (b_gnt) begin
         ram_load    = b_we;
         ram_address = b_addr;
         ram_data    = b_wdata;
      end
   end

   always_comb begin
      state_nx    = state;
      lock_cnt_nx = lock_cnt;
      prio_b_nx   = prio_b;
      if (a_gnt) prio_b_nx = 1'b1;
      if (b_gnt) prio_b_nx = 1'b0;
      case (state)
         UNLOCKED: begin
            // a cap of 1 means the entry grant already exhausts the burst
            if (b_gnt && b_lock && MAX_LOCK > 1) begin
               state_nx    = LOCKED;
               lock_cnt_nx = CW'(1);
            end
         end
         LOCKED: begin
            if (!b_req || !b_lock) begin
               state_nx    = UNLOCKED;
               lock_cnt_nx = '0;
            end else if (lock_cnt == CW'(MAX_LOCK - 1)) begin
               state_nx    = UNLOCKED;
               lock_cnt_nx = '0;
               prio_b_nx   = 1'b0;
            end else begin
               lock_cnt_nx = lock_cnt + CW'(1);
            end
         end
         default: begin
            state_nx    = UNLOCKED;
            lock_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= UNLOCKED;
         lock_cnt <= '0;
         prio_b   <= 1'b0;
         rd_vld   <= 1'b0;
         rd_own   <= 1'b0;
      end else begin
         state    <= state_nx;
         lock_cnt <= lock_cnt_nx;
         prio_b   <= prio_b_nx;
         rd_vld   <= (a_gnt && !a_we) || (b_gnt && !b_we);
         rd_own   <= b_gnt;
      end
   end

   assign a_rvalid = rd_vld && !rd_own;
   assign b_rvalid = rd_vld && rd_own;
   assign a_rdata  = a_rvalid ? ram_out : '0;
   assign b_rdata  = b_rvalid ? ram_out : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM behind it (MAX_LOCK=4).
module tb_ram_arbiter;
   localparam int AW = 13;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we, b_req, b_we, b_lock;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic [DW-1:0] ram_data, ram_out;
   logic          ram_load;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int nvec = 0;
   int nerr = 0;

   ram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_load) mem[ram_address] <= ram_data;
      ram_out <= mem[ram_address];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drv_a(input logic req, input logic we, input int addr, input int wd);
      a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = DW'(wd);
   endtask

   task automatic drv_b(input logic req, input logic we, input int addr, input int wd, input logic lk);
      b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = DW'(wd); b_lock = lk;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] lock_seq;
      reset = 1'b1;
      drv_a(0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0);
      tick(); tick();
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);
      reset = 1'b0;

      // preload RAM[5]=3 through port A
      drv_a(1, 1, 5, 16'h0003);
      #1;
      chk("pre_gnt", {a_gnt, b_gnt}, 2'b10);
      chk("pre_load", {ram_load, ram_address}, {1'b1, 13'd5});
      chk("pre_data", ram_data, 16'h0003);
      tick();
      chk("pre_no_rvalid", a_rvalid, 0);

      // 1: A read addr 5
      drv_a(1, 0, 5, 0);
      #1;
      chk("t1_gnt", {a_gnt, b_gnt}, 2'b10);
      chk("t1_load", ram_load, 0);
      tick();
      drv_a(0, 0, 0, 0);
      chk("t1_rvalid", {a_rvalid, b_rvalid}, 2'b10);
      chk("t1_rdata", a_rdata, 16'h0003);

      // 6: idle; prio stays on B (set by the last A grant)
      #1;
      chk("t6_gnt", {a_gnt, b_gnt}, 2'b00);
      chk("t6_drive", {ram_load, ram_address, ram_data}, 0);
      tick();
      chk("t6_rvalid", {a_rvalid, b_rvalid}, 2'b00);

      // 2: both read every cycle, prio=B so grants go B,A,B,A
      drv_a(1, 0, 5, 0);
      drv_b(1, 0, 5, 0, 0);
      for (int i = 0; i < 4; i++) begin
         logic eb;
         eb = (i % 2 == 0);
         #1;
         chk($sformatf("t2_gnt%0d", i), {a_gnt, b_gnt}, {!eb, eb});
         tick();
         chk($sformatf("t2_rv%0d", i), {a_rvalid, b_rvalid}, {!eb, eb});
         chk($sformatf("t2_rd%0d", i), {a_rdata, b_rdata},
             eb ? {16'h0000, 16'h0003} : {16'h0003, 16'h0000});
      end
      drv_a(0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0);

      // 3: B write 100 <= BEEF, then A reads it back
      drv_b(1, 1, 100, 16'hBEEF, 0);
      #1;
      chk("t3_bgnt", {a_gnt, b_gnt}, 2'b01);
      chk("t3_drive", {ram_load, ram_address, ram_data}, {1'b1, 13'd100, 16'hBEEF});
      tick();
      chk("t3_no_brvalid", {a_rvalid, b_rvalid}, 2'b00);
      drv_b(0, 0, 0, 0, 0);
      drv_a(1, 0, 100, 0);
      #1;
      chk("t3_agnt", {a_gnt, b_gnt}, 2'b10);
      tick();
      chk("t3_rdata", {a_rvalid, a_rdata}, {1'b1, 16'hBEEF});
      drv_a(0, 0, 0, 0);

      // 4: lock entry with B alone, then A joins: B,B,B,B (cap 4), A, B, B
      lock_seq = 7'b1101111;
      drv_b(1, 0, 100, 0, 1);
      for (int i = 0; i < 7; i++) begin
         if (i == 1) drv_a(1, 0, 5, 0);
         #1;
         chk($sformatf("t4_gnt%0d", i), {a_gnt, b_gnt}, {!lock_seq[i], lock_seq[i]});
         tick();
      end
      drv_a(0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0);
      tick();

      // 5: A read accepted by grant, reset hits before the edge -> read dropped
      drv_a(1, 0, 5, 0);
      #1;
      chk("t5_gnt_pre", a_gnt, 1);
      reset = 1'b1;
      #1;
      chk("t5_gnt_rst", {a_gnt, b_gnt}, 2'b00);
      chk("t5_drive_rst", {ram_load, ram_address, ram_data}, 0);
      tick();
      chk("t5_rvalid", {a_rvalid, b_rvalid}, 2'b00);
      chk("t5_rdata", a_rdata, 0);
      reset = 1'b0;
      drv_a(0, 0, 0, 0);
      tick();
      chk("t5_rvalid_after", a_rvalid, 0);

      // after reset prio is A again
      drv_a(1, 0, 5, 0);
      drv_b(1, 0, 5, 0, 0);
      #1;
      chk("rst_prio", {a_gnt, b_gnt}, 2'b10);
      tick();
      drv_a(0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
